// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Definitions shared by the memory arbiter and its grant picker:
//   REG_BUS        - data/address width of the shared memory port
//   arb_state_t    - 2-bit arbiter FSM encoding (IDLE, REQ, WAIT, RESP)
//   ARB_OWNER_IF   - owner code for the instruction-fetch requester
//   ARB_OWNER_ME   - owner code for the data (MEM stage) requester
package mem_arbiter_pkg;

  localparam int REG_BUS = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  localparam logic ARB_OWNER_IF = 1'b0;
  localparam logic ARB_OWNER_ME = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational grant picker for the memory arbiter.
// Ports:
//   if_req      in   fetch request pending
//   me_req      in   data request pending
//   last_grant  in   owner granted most recently (used only with round robin)
//   grant_valid out  at least one request pending
//   grant_owner out  owner to be granted (ARB_OWNER_IF / ARB_OWNER_ME)
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   - on contention, grant the requester not granted last
//   undefined - fixed data-over-fetch priority, last_grant ignored
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic me_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  // A lone requester always wins; only contention consults the policy.
  always_comb begin
    grant_valid = if_req | me_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req && me_req) begin
      grant_owner = (last_grant == ARB_OWNER_ME) ? ARB_OWNER_IF : ARB_OWNER_ME;
    end else begin
      grant_owner = me_req ? ARB_OWNER_ME : ARB_OWNER_IF;
    end
`else
    grant_owner = me_req ? ARB_OWNER_ME : ARB_OWNER_IF;
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the history bit.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the fetch (IF) and data (MEM) requesters,
// serialising one transaction at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   if_req, if_addr               fetch request, held until if_done
//   if_rdata, if_done             held fetch data, one-cycle completion pulse
//   me_req, me_we, me_addr,
//   me_wdata, me_wmask            data request payload, held until me_done
//   me_rdata, me_done             held load data, one-cycle completion pulse
//   mem_valid, mem_ready          request handshake toward memory
//   mem_we, mem_addr,
//   mem_wdata, mem_wmask          latched request payload
//   mem_rvalid, mem_rdata         memory response / ack
//   busy                          FSM not in IDLE (for the hazard unit)
// Configuration macro: ARB_ROUND_ROBIN_EN (see mem_arb_pick); when defined a
// last-grant register alternates grants under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [REG_BUS-1:0] if_addr,
  output logic [REG_BUS-1:0] if_rdata,
  output logic               if_done,
  input  logic               me_req,
  input  logic               me_we,
  input  logic [REG_BUS-1:0] me_addr,
  input  logic [REG_BUS-1:0] me_wdata,
  input  logic [REG_BUS-1:0] me_wmask,
  output logic [REG_BUS-1:0] me_rdata,
  output logic               me_done,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic               mem_we,
  output logic [REG_BUS-1:0] mem_addr,
  output logic [REG_BUS-1:0] mem_wdata,
  output logic [REG_BUS-1:0] mem_wmask,
  input  logic               mem_rvalid,
  input  logic [REG_BUS-1:0] mem_rdata,
  output logic               busy
);

  arb_state_t state;
  logic       owner;
  logic       last_grant;
  logic       grant_valid;
  logic       grant_owner;

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .me_req      (me_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last; reset as if fetch went last so data
  // wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ARB_OWNER_IF;
    end else if (state == ST_IDLE && grant_valid) begin
      last_grant <= grant_owner;
    end
  end
`else
  assign last_grant = ARB_OWNER_IF;
`endif

  // Arbiter FSM. All outputs are registered here so they change only with
  // the state; the payload is latched once in IDLE and held through REQ.
  // Responses are accepted only in WAIT, so a stray rvalid elsewhere is
  // simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= ARB_OWNER_IF;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      if_rdata  <= '0;
      me_rdata  <= '0;
      if_done   <= 1'b0;
      me_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner <= grant_owner;
            if (grant_owner == ARB_OWNER_ME) begin
              mem_we    <= me_we;
              mem_addr  <= me_addr;
              mem_wdata <= me_wdata;
              mem_wmask <= me_wmask;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
            mem_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (owner == ARB_OWNER_ME) begin
              // A write ack carries no data; keep the last load result.
              if (!mem_we) begin
                me_rdata <= mem_rdata;
              end
              me_done <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if_done <= 1'b0;
          me_done <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
